alu_cmd_queue: RTL and testbench

Command buffer and issue stage placed directly upstream of the 4-bit registered ALU. It accepts ALU commands (operands a, b and op code) over a valid/ready handshake, buffers up to DEPTH of them in FIFO order, and drives the ALU input ports one command per cycle when downstream allows. It also produces a result-valid strobe and sequence tag that line up with the ALU's registered result, so consumers know which result belongs to which command.

---
 rtl/alu_cmd_queue.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO and issue stage in front of the 4-bit registered ALU.
// Buffers up to DEPTH commands, issues one per cycle when issue_en_i allows, and
// produces a result-valid strobe and sequence tag aligned with the ALU's registered result.
// Optional build macro: ALU_CMD_STATS_EN enables the saturating issued-command counter;
// without it issue_count_o is tied to zero.
module alu_cmd_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [3:0]               in_a_i,
  input  logic [3:0]               in_b_i,
  input  logic [1:0]               in_op_i,
  input  logic                     issue_en_i,
  output logic [3:0]               alu_a_o,
  output logic [3:0]               alu_b_o,
  output logic [1:0]               alu_op_o,
  output logic                     alu_issue_o,
  output logic                     res_valid_o,
  output logic [3:0]               res_tag_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              issue_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  // Entry layout: {a, b, op}
  logic [9:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      tag_ctr_q, tag_ctr_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [3:0]      alu_tag_q, alu_tag_d;
  logic            alu_issue_q, alu_issue_d;
  logic            res_valid_q;
  logic [3:0]      res_tag_q;
  logic            push, pop;
  logic [9:0]      head;

  // in_ready depends on occupancy only, so there is no path from issue_en_i.
  assign in_ready_o = (count_q != FullCnt);
  assign head       = mem_q[rd_ptr_q];

  // Handshake decode and next-state for pointers, occupancy and the issue stage.
  always_comb begin
    push        = in_valid_i && in_ready_o;
    pop         = issue_en_i && (count_q != '0);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tag_ctr_d   = tag_ctr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_tag_d   = alu_tag_q;
    alu_issue_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PtrW'(1);
      alu_a_d     = head[9:6];
      alu_b_d     = head[5:2];
      alu_op_d    = head[1:0];
      alu_tag_d   = tag_ctr_q;
      tag_ctr_d   = tag_ctr_q + 4'd1;
      alu_issue_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents are don't-care after reset since pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a_i, in_b_i, in_op_i};
    end
  end

  // Queue control and issue-stage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_ctr_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_tag_q   <= '0;
      alu_issue_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_ctr_q   <= tag_ctr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_tag_q   <= alu_tag_d;
      alu_issue_q <= alu_issue_d;
    end
  end

  // Result strobe trails the issue by one edge, matching the ALU's output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      res_valid_q <= alu_issue_q;
      res_tag_q   <= alu_tag_q;
    end
  end

`ifdef ALU_CMD_STATS_EN
  logic [15:0] issue_count_q;

  // Saturating count of issue edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_count_q <= '0;
    end else if (pop && (issue_count_q != 16'hFFFF)) begin
      issue_count_q <= issue_count_q + 16'd1;
    end
  end

  assign issue_count_o = issue_count_q;
`else
  assign issue_count_o = 16'h0000;
`endif

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign alu_issue_o = alu_issue_q;
  assign res_valid_o = res_valid_q;
  assign res_tag_o   = res_tag_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed bench for alu_cmd_queue with a small registered ALU model
// on the issue outputs and a scoreboard of hand-computed result tags and values.
module tb_alu_cmd_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      in_a_i;
  logic [3:0]      in_b_i;
  logic [1:0]      in_op_i;
  logic            issue_en_i;
  logic [3:0]      alu_a_o;
  logic [3:0]      alu_b_o;
  logic [1:0]      alu_op_o;
  logic            alu_issue_o;
  logic            res_valid_o;
  logic [3:0]      res_tag_o;
  logic [CntW-1:0] count_o;
  logic [15:0]     issue_count_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] alu_res;
  logic [3:0] exp_tag_q [$];
  logic [3:0] exp_res_q [$];

  always #5 clk_i = ~clk_i;

  alu_cmd_queue #(.DEPTH(DEPTH)) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_a_i        (in_a_i),
    .in_b_i        (in_b_i),
    .in_op_i       (in_op_i),
    .issue_en_i    (issue_en_i),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_op_o      (alu_op_o),
    .alu_issue_o   (alu_issue_o),
    .res_valid_o   (res_valid_o),
    .res_tag_o     (res_tag_o),
    .count_o       (count_o),
    .issue_count_o (issue_count_o)
  );

  // Downstream 4-bit registered ALU
  always_ff @(posedge clk_i) begin
    case (alu_op_o)
      2'b00:   alu_res <= alu_a_o + alu_b_o;
      2'b01:   alu_res <= alu_a_o - alu_b_o;
      2'b10:   alu_res <= alu_a_o & alu_b_o;
      default: alu_res <= alu_a_o | alu_b_o;
    endcase
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_res(input logic [3:0] tag, input logic [3:0] res);
    exp_tag_q.push_back(tag);
    exp_res_q.push_back(res);
  endtask

  // Advance one edge, sample 1 ns later, and score any valid result.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (res_valid_o) begin
      if (exp_tag_q.size() == 0) begin
        check_eq("res_unexpected", int'(res_valid_o), 0);
      end else begin
        check_eq("res_tag", int'(res_tag_o), int'(exp_tag_q[0]));
        check_eq("res_data", int'(alu_res), int'(exp_res_q[0]));
        void'(exp_tag_q.pop_front());
        void'(exp_res_q.pop_front());
      end
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op);
    in_valid_i = v;
    in_a_i     = a;
    in_b_i     = b;
    in_op_i    = op;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    issue_en_i = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step();
    step();
    rst_i = 1'b0;
    exp_tag_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] fa [5];
    logic [3:0] fb [5];
    logic [1:0] fo [5];
    logic [3:0] fr [5];
    int         exp_stats;
    fa = '{4'h7, 4'h9, 4'hC, 4'h5, 4'h1};
    fb = '{4'h2, 4'h4, 4'hA, 4'hA, 4'h1};
    fo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    fr = '{4'h9, 4'h5, 4'h8, 4'hF, 4'h2};

    // Reset state
    do_reset();
    check_eq("rst_count", int'(count_o), 0);
    check_eq("rst_in_ready", int'(in_ready_o), 1);
    check_eq("rst_alu_issue", int'(alu_issue_o), 0);
    check_eq("rst_res_valid", int'(res_valid_o), 0);
    check_eq("rst_res_tag", int'(res_tag_o), 0);
    check_eq("rst_alu_a", int'(alu_a_o), 0);
    check_eq("rst_issue_count", int'(issue_count_o), 0);

    // Single command: 3 + 5 = 8, tag 0
    expect_res(4'd0, 4'd8);
    issue_en_i = 1'b1;
    drive(1'b1, 4'd3, 4'd5, 2'b00);
    step();
    drive(1'b0, 4'd0, 4'd0, 2'b00);
    check_eq("single_count", int'(count_o), 1);
    check_eq("single_no_bypass", int'(alu_issue_o), 0);
    step();
    check_eq("single_issue", int'(alu_issue_o), 1);
    check_eq("single_alu_a", int'(alu_a_o), 3);
    check_eq("single_alu_b", int'(alu_b_o), 5);
    check_eq("single_alu_op", int'(alu_op_o), 0);
    step();
    check_eq("single_res_valid", int'(res_valid_o), 1);
    step();
    check_eq("single_res_done", int'(res_valid_o), 0);
    check_eq("single_drained", exp_tag_q.size(), 0);

    // Fill to DEPTH with issue blocked; the fifth is held by the source
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fa[i], fb[i], fo[i]);
      step();
    end
    check_eq("fill_count", int'(count_o), 4);
    check_eq("fill_in_ready", int'(in_ready_o), 0);
    drive(1'b1, fa[4], fb[4], fo[4]);
    step();
    check_eq("fill_hold_count", int'(count_o), 4);
    check_eq("fill_hold_issue", int'(alu_issue_o), 0);
    for (int i = 0; i < 5; i++) expect_res(4'(i), fr[i]);
    issue_en_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 1) begin
        check_eq("fill_fifth_accepted", int'(count_o), 3);
        in_valid_i = 1'b0;
      end
    end
    check_eq("fill_drained", exp_tag_q.size(), 0);
    check_eq("fill_empty", int'(count_o), 0);

    // Streaming 20 commands, tag wraps 15 -> 0
    do_reset();
    issue_en_i = 1'b1;
    for (int i = 0; i < 20; i++) expect_res(4'(i), 4'(i + 1));
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'(i), 4'd1, 2'b00);
      step();
      check_eq("stream_count_le1", int'(count_o <= 1), 1);
      check_eq("stream_issue", int'(alu_issue_o), int'(i >= 1));
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("stream_drained", exp_tag_q.size(), 0);

    // Stall mid-stream: outputs hold, nothing lost or duplicated
    do_reset();
    drive(1'b1, 4'd2, 4'd3, 2'b00); step();
    drive(1'b1, 4'd8, 4'd3, 2'b01); step();
    drive(1'b1, 4'd6, 4'd3, 2'b10); step();
    in_valid_i = 1'b0;
    expect_res(4'd0, 4'd5);
    expect_res(4'd1, 4'd5);
    expect_res(4'd2, 4'd2);
    issue_en_i = 1'b1;
    step();
    check_eq("stall_first_a", int'(alu_a_o), 2);
    issue_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_issue", int'(alu_issue_o), 0);
      check_eq("stall_hold_a", int'(alu_a_o), 2);
      check_eq("stall_hold_b", int'(alu_b_o), 3);
      check_eq("stall_hold_op", int'(alu_op_o), 0);
    end
    check_eq("stall_count", int'(count_o), 2);
    issue_en_i = 1'b1;
    step();
    check_eq("stall_resume_a", int'(alu_a_o), 8);
    check_eq("stall_resume_op", int'(alu_op_o), 1);
    step();
    check_eq("stall_third_a", int'(alu_a_o), 6);
    step();
    step();
    check_eq("stall_drained", exp_tag_q.size(), 0);
    check_eq("stall_empty", int'(count_o), 0);

    // Reset with count = 3 and res_valid = 1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd1, 4'd1, 2'b00);
      step();
    end
    in_valid_i = 1'b0;
    expect_res(4'd0, 4'd2);
    issue_en_i = 1'b1;
    step();
    issue_en_i = 1'b0;
    step();
    check_eq("midrst_pre_count", int'(count_o), 3);
    check_eq("midrst_pre_res_valid", int'(res_valid_o), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_eq("midrst_count", int'(count_o), 0);
    check_eq("midrst_res_valid", int'(res_valid_o), 0);
    check_eq("midrst_in_ready", int'(in_ready_o), 1);
    check_eq("midrst_alu_issue", int'(alu_issue_o), 0);
    check_eq("midrst_issue_count", int'(issue_count_o), 0);
    expect_res(4'd0, 4'd3);
    issue_en_i = 1'b1;
    drive(1'b1, 4'd1, 4'd2, 2'b00);
    step();
    in_valid_i = 1'b0;
    step();
    check_eq("midrst_reissue", int'(alu_issue_o), 1);
    check_eq("midrst_reissue_a", int'(alu_a_o), 1);
    step();
    step();
    check_eq("midrst_drained", exp_tag_q.size(), 0);

    // Issue counter after 7 issues
    do_reset();
    issue_en_i = 1'b1;
    for (int i = 0; i < 7; i++) expect_res(4'(i), 4'(i));
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i), 4'(i), 2'b10);
      step();
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
`ifdef ALU_CMD_STATS_EN
    exp_stats = 7;
`else
    exp_stats = 0;
`endif
    check_eq("stats_issue_count", int'(issue_count_o), exp_stats);
    check_eq("stats_drained", exp_tag_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
